// File: rtl/div_pkg.sv
// div_pkg
// Shared definitions for the sub-shift divider slice.
//   div_state_e : FSM state enumeration (IDLE, CALC, FIXUP, DONE)
//   cnt_width   : width of an iteration counter that must hold 0..n
package div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } div_state_e;

    // Counter width able to represent every value from 0 up to n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/div_subshift_step.sv
// div_subshift_step
// One restoring division iteration, purely combinational.
// Ports:
//   rem_in  [DATA_W] : partial remainder before this iteration (always < divisor)
//   dvd_bit [1]      : next dividend bit shifted into the remainder
//   divisor [DATA_W] : divisor magnitude
//   rem_out [DATA_W] : partial remainder after this iteration
//   q_bit   [1]      : quotient bit produced by this iteration
module div_subshift_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem_in,
    input  logic              dvd_bit,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_out,
    output logic              q_bit
);

    logic [DATA_W:0] shifted;
    logic [DATA_W:0] diff;

    // Because rem_in < divisor, the shifted value is below 2*divisor, so the
    // DATA_W+1 bit difference is exact and its top bit is a true sign bit.
    // Both kept results also fit back into DATA_W bits.
    always_comb begin
        shifted = {rem_in, dvd_bit};
        diff    = shifted - {1'b0, divisor};
        q_bit   = ~diff[DATA_W];
        rem_out = q_bit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
    end

endmodule

// File: rtl/div_subshift_gen.sv
// div_subshift_gen
// Iterative restoring divider, STEPS iterations per clock, signed or unsigned.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   in_valid / in_ready     : request handshake (ready only when idle)
//   signed_op               : 1 = two's-complement division, 0 = unsigned
//   dividend, divisor       : operands, sampled on acceptance
//   out_valid / out_ready   : result handshake (valid only in DONE)
//   quotient, remainder     : registered results
//   div_by_zero             : registered flag, current result had divisor == 0
module div_subshift_gen
    import div_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int STEPS  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              signed_op,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              div_by_zero
);

    localparam int N  = DATA_W / STEPS;
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    if (DATA_W < 4 || (DATA_W % 2) != 0 || STEPS < 1 || (DATA_W % STEPS) != 0) begin : g_bad_param
        $error("div_subshift_gen: DATA_W must be even and >= 4, and STEPS must divide DATA_W");
    end

    div_state_e        state;
    div_state_e        state_next;
    logic [CW-1:0]     cnt;
    logic              sop;
    logic              neg_dvd;
    logic              neg_dvs;
    logic [DATA_W-1:0] work_q;
    logic [DATA_W-1:0] work_r;
    logic [DATA_W-1:0] work_d;
    logic [DATA_W-1:0] abs_dvd;
    logic [DATA_W-1:0] abs_dvs;
    logic [DATA_W-1:0] calc_q;
    logic [DATA_W-1:0] calc_r;
    logic              accept;
    logic              dvs_zero;

    assign accept   = in_valid & in_ready;
    assign dvs_zero = (divisor == '0);

    // Magnitudes are only taken in signed mode; MIN maps to itself, which the
    // unsigned core then treats as 2^(DATA_W-1), giving the wrap-around result.
    assign abs_dvd = (signed_op && dividend[DATA_W-1]) ? -dividend : dividend;
    assign abs_dvs = (signed_op && divisor[DATA_W-1])  ? -divisor  : divisor;

    // Chain of STEPS iterations. work_q holds the not-yet-consumed dividend
    // bits in its upper part and collects quotient bits from the bottom.
    for (genvar i = 0; i < STEPS; i++) begin : g_step
        logic [DATA_W-1:0] rem_i;
        logic [DATA_W-1:0] dvd_i;
        logic [DATA_W-1:0] rem_o;
        logic [DATA_W-1:0] dvd_o;
        logic              q_bit;

        if (i == 0) begin : g_first
            assign rem_i = work_r;
            assign dvd_i = work_q;
        end else begin : g_next
            assign rem_i = g_step[i-1].rem_o;
            assign dvd_i = g_step[i-1].dvd_o;
        end

        div_subshift_step #(
            .DATA_W (DATA_W)
        ) u_step (
            .rem_in  (rem_i),
            .dvd_bit (dvd_i[DATA_W-1]),
            .divisor (work_d),
            .rem_out (rem_o),
            .q_bit   (q_bit)
        );

        assign dvd_o = {dvd_i[DATA_W-2:0], q_bit};
    end

    assign calc_q = g_step[STEPS-1].dvd_o;
    assign calc_r = g_step[STEPS-1].rem_o;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a zero divisor skips the iteration phase entirely.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = dvs_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == LAST_CNT) begin
                    state_next = FIXUP;
                end
            end
            FIXUP: begin
                state_next = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Handshake outputs decoded from the state
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Datapath: the visible result registers only change on a divide-by-zero
    // acceptance or in FIXUP, so the previous result stays readable until then.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            sop         <= 1'b0;
            neg_dvd     <= 1'b0;
            neg_dvs     <= 1'b0;
            work_q      <= '0;
            work_r      <= '0;
            work_d      <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt         <= '0;
                        sop         <= signed_op;
                        neg_dvd     <= signed_op & dividend[DATA_W-1];
                        neg_dvs     <= signed_op & divisor[DATA_W-1];
                        work_q      <= abs_dvd;
                        work_r      <= '0;
                        work_d      <= abs_dvs;
                        div_by_zero <= dvs_zero;
                        if (dvs_zero) begin
                            quotient  <= '1;
                            remainder <= dividend;
                        end
                    end
                end
                CALC: begin
                    work_q <= calc_q;
                    work_r <= calc_r;
                    cnt    <= cnt + CW'(1);
                end
                FIXUP: begin
                    quotient  <= (sop && (neg_dvd != neg_dvs)) ? -work_q : work_q;
                    remainder <= neg_dvd ? -work_r : work_r;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
